// File: rtl/cdc_handshake_rx_if.sv
// Bundle of the four-phase req/ack handshake (source side) and the
// valid/ready stream (destination side) handled by cdc_handshake_rx.
interface cdc_handshake_rx_if #(
  parameter int WIDTH = 32
);
  logic             src_req;
  logic [WIDTH-1:0] src_data;
  logic             dest_ack;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
  logic             busy;

  // Environment view: drives the request, the source word and downstream ready.
  modport master (
    output src_req,
    output src_data,
    output m_ready,
    input  dest_ack,
    input  m_valid,
    input  m_data,
    input  busy
  );

  // Responder view: the destination-domain receiver.
  modport slave (
    input  src_req,
    input  src_data,
    input  m_ready,
    output dest_ack,
    output m_valid,
    output m_data,
    output busy
  );
endinterface

// File: rtl/cdc_handshake_rx.sv
// Destination-domain responder of a four-phase req/ack CDC handshake.
// The request level is synchronized; the data word is sampled unsynchronized
// only once the synchronized request is high, when the source holds it stable.
// The word is offered as a valid/ready stream and acknowledged from a flop.
module cdc_handshake_rx #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                 dest_clk,
  input  logic                 rst_n,
  cdc_handshake_rx_if.slave    bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] VALID = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] req_sync;
  logic                req_s;
  logic [1:0]          state;
  logic                dest_ack_r;
  logic                m_valid_r;
  logic [WIDTH-1:0]    m_data_r;

  assign req_s = req_sync[STAGES-1];

  // Request synchronizer chain; req_s is the last flop.
  always_ff @(posedge dest_clk) begin
    if (!rst_n) begin
      req_sync <= '0;
    end else begin
      req_sync <= {req_sync[STAGES-2:0], bus.src_req};
    end
  end

  // Handshake FSM: capture on request, hold until accepted, ack until request falls.
  always_ff @(posedge dest_clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      dest_ack_r <= 1'b0;
      m_valid_r  <= 1'b0;
      m_data_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          dest_ack_r <= 1'b0;
          m_valid_r  <= 1'b0;
          if (req_s) begin
            m_data_r  <= bus.src_data;
            m_valid_r <= 1'b1;
            state     <= VALID;
          end
        end
        VALID: begin
          if (bus.m_ready) begin
            m_valid_r  <= 1'b0;
            dest_ack_r <= 1'b1;
            state      <= ACK;
          end
        end
        ACK: begin
          // Request must go low before another word can be captured.
          if (!req_s) begin
            dest_ack_r <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          dest_ack_r <= 1'b0;
          m_valid_r  <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  assign bus.dest_ack = dest_ack_r;
  assign bus.m_valid  = m_valid_r;
  assign bus.m_data   = m_data_r;
  assign bus.busy     = (state != IDLE);

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed bench for cdc_handshake_rx: one instance with WIDTH=32/STAGES=2
// and one with WIDTH=1/STAGES=3 sharing clock and reset.
module tb_cdc_handshake_rx;
  logic dest_clk = 1'b0;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cnt;
  int   base;

  cdc_handshake_rx_if #(.WIDTH(32)) bus_a ();
  cdc_handshake_rx_if #(.WIDTH(1))  bus_b ();

  cdc_handshake_rx #(.WIDTH(32), .STAGES(2)) dut (
    .dest_clk (dest_clk),
    .rst_n    (rst_n),
    .bus      (bus_a)
  );

  cdc_handshake_rx #(.WIDTH(1), .STAGES(3)) dut_s3 (
    .dest_clk (dest_clk),
    .rst_n    (rst_n),
    .bus      (bus_b)
  );

  always #5 dest_clk = ~dest_clk;

  // Record every word accepted on the wide instance's stream.
  logic [31:0] got_a[$];
  always @(posedge dest_clk) begin
    if (bus_a.m_valid && bus_a.m_ready) got_a.push_back(bus_a.m_data);
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge dest_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst_n = 1'b0;
    bus_a.src_req = 1'b0; bus_a.src_data = '0; bus_a.m_ready = 1'b0;
    bus_b.src_req = 1'b0; bus_b.src_data = '0; bus_b.m_ready = 1'b0;
    steps(2);
    chk("rst_ack",   bus_a.dest_ack, 0);
    chk("rst_valid", bus_a.m_valid,  0);
    chk("rst_data",  bus_a.m_data,   0);
    chk("rst_busy",  bus_a.busy,     0);
    chk("rst_b_valid", bus_b.m_valid, 0);
    chk("rst_b_ack",   bus_b.dest_ack, 0);
    rst_n = 1'b1;
    step();

    // Basic transfer, m_ready tied high.
    base = got_a.size();
    bus_a.src_data = 32'hDEADBEEF; bus_a.src_req = 1'b1; bus_a.m_ready = 1'b1;
    step();
    chk("basic_e0_valid", bus_a.m_valid, 0);
    step();
    chk("basic_e1_valid", bus_a.m_valid, 0);
    step();
    chk("basic_e2_valid", bus_a.m_valid, 1);
    chk("basic_e2_data",  bus_a.m_data,  32'hDEADBEEF);
    chk("basic_e2_ack",   bus_a.dest_ack, 0);
    chk("basic_e2_busy",  bus_a.busy,    1);
    step();
    chk("basic_e3_ack",   bus_a.dest_ack, 1);
    chk("basic_e3_valid", bus_a.m_valid, 0);
    bus_a.src_req = 1'b0;
    steps(2);
    chk("basic_rel_f1_ack", bus_a.dest_ack, 1);
    step();
    chk("basic_rel_f2_ack",  bus_a.dest_ack, 0);
    chk("basic_rel_f2_busy", bus_a.busy, 0);
    chk("basic_words", got_a.size() - base, 1);
    if (got_a.size() > base) chk("basic_word0", got_a[base], 32'hDEADBEEF);

    // Backpressure: ten cycles of m_ready=0 with the source word changing underneath.
    base = got_a.size();
    bus_a.m_ready = 1'b0; bus_a.src_data = 32'h12345678; bus_a.src_req = 1'b1;
    steps(3);
    chk("bp_valid_rise", bus_a.m_valid, 1);
    bus_a.src_data = 32'hFFFFFFFF;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_valid_hold", bus_a.m_valid, 1);
      chk("bp_data_hold",  bus_a.m_data,  32'h12345678);
      chk("bp_ack_low",    bus_a.dest_ack, 0);
    end
    bus_a.m_ready = 1'b1;
    step();
    chk("bp_accept_ack",   bus_a.dest_ack, 1);
    chk("bp_accept_valid", bus_a.m_valid, 0);
    bus_a.src_req = 1'b0;
    steps(3);
    chk("bp_release_ack", bus_a.dest_ack, 0);
    chk("bp_words", got_a.size() - base, 1);
    if (got_a.size() > base) chk("bp_word0", got_a[base], 32'h12345678);

    // Held request: no duplicate word while src_req stays high.
    base = got_a.size();
    bus_a.src_data = 32'hA5A5A5A5; bus_a.src_req = 1'b1; bus_a.m_ready = 1'b1;
    steps(4);
    chk("held_ack_rise", bus_a.dest_ack, 1);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("held_no_valid", bus_a.m_valid, 0);
      chk("held_ack_high", bus_a.dest_ack, 1);
    end
    bus_a.src_req = 1'b0;
    steps(3);
    chk("held_release_ack", bus_a.dest_ack, 0);
    chk("held_words", got_a.size() - base, 1);

    // Back-to-back words 1, 2, 3 with random m_ready.
    base = got_a.size();
    for (int k = 1; k <= 3; k++) begin
      bus_a.src_data = k; bus_a.src_req = 1'b1;
      cnt = 0;
      while (bus_a.dest_ack !== 1'b1 && cnt < 100) begin
        bus_a.m_ready = 1'($urandom_range(0, 1));
        step();
        cnt++;
      end
      chk("b2b_ack_in_time", 32'(cnt < 100), 1);
      bus_a.src_req = 1'b0;
      cnt = 0;
      while (bus_a.dest_ack !== 1'b0 && cnt < 100) begin
        bus_a.m_ready = 1'($urandom_range(0, 1));
        step();
        cnt++;
      end
      chk("b2b_release_in_time", 32'(cnt < 100), 1);
    end
    chk("b2b_words", got_a.size() - base, 3);
    for (int k = 0; k < 3; k++) begin
      if (got_a.size() > base + k) chk("b2b_seq", got_a[base + k], 32'(k + 1));
    end

    // Reset for one cycle while VALID with the request still high.
    base = got_a.size();
    bus_a.m_ready = 1'b0; bus_a.src_data = 32'h0BADF00D; bus_a.src_req = 1'b1;
    steps(3);
    chk("rmid_valid_before", bus_a.m_valid, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rmid_ack",   bus_a.dest_ack, 0);
    chk("rmid_valid", bus_a.m_valid,  0);
    chk("rmid_data",  bus_a.m_data,   0);
    chk("rmid_busy",  bus_a.busy,     0);
    steps(2);
    chk("rmid_r2_valid", bus_a.m_valid, 0);
    step();
    chk("rmid_redeliver_valid", bus_a.m_valid, 1);
    chk("rmid_redeliver_data",  bus_a.m_data,  32'h0BADF00D);
    bus_a.m_ready = 1'b1;
    step();
    chk("rmid_ack_after", bus_a.dest_ack, 1);
    bus_a.src_req = 1'b0;
    steps(3);
    chk("rmid_release_ack", bus_a.dest_ack, 0);
    chk("rmid_words", got_a.size() - base, 1);

    // STAGES=3, WIDTH=1 instance: latency, release, backpressure, reset.
    bus_b.m_ready = 1'b1; bus_b.src_data = 1'b1; bus_b.src_req = 1'b1;
    steps(3);
    chk("s3_e2_valid", bus_b.m_valid, 0);
    step();
    chk("s3_e3_valid", bus_b.m_valid, 1);
    chk("s3_e3_data",  bus_b.m_data,  1);
    step();
    chk("s3_ack", bus_b.dest_ack, 1);
    bus_b.src_req = 1'b0;
    steps(3);
    chk("s3_rel_f2_ack", bus_b.dest_ack, 1);
    step();
    chk("s3_rel_f3_ack",  bus_b.dest_ack, 0);
    chk("s3_rel_f3_busy", bus_b.busy, 0);

    bus_b.m_ready = 1'b0; bus_b.src_data = 1'b1; bus_b.src_req = 1'b1;
    steps(4);
    chk("s3_bp_valid", bus_b.m_valid, 1);
    bus_b.src_data = 1'b0;
    steps(5);
    chk("s3_bp_hold_valid", bus_b.m_valid, 1);
    chk("s3_bp_hold_data",  bus_b.m_data,  1);
    chk("s3_bp_ack_low",    bus_b.dest_ack, 0);
    bus_b.src_data = 1'b1;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("s3_rmid_valid", bus_b.m_valid, 0);
    chk("s3_rmid_data",  bus_b.m_data,  0);
    chk("s3_rmid_busy",  bus_b.busy,    0);
    steps(3);
    chk("s3_rmid_r3_valid", bus_b.m_valid, 0);
    step();
    chk("s3_redeliver_valid", bus_b.m_valid, 1);
    chk("s3_redeliver_data",  bus_b.m_data,  1);
    bus_b.m_ready = 1'b1;
    step();
    chk("s3_rmid_ack", bus_b.dest_ack, 1);
    bus_b.src_req = 1'b0;
    steps(4);
    chk("s3_final_ack",  bus_b.dest_ack, 0);
    chk("s3_final_busy", bus_b.busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/cdc_handshake_rx.md
# cdc_handshake_rx

Destination-domain responder of a four-phase req/ack clock-domain-crossing handshake. It synchronizes an asynchronous request, captures a multi-bit data word that the source holds stable, and presents it as a valid/ready stream. It returns a registered acknowledge to the source domain. It is the counterpart of the source-side initiator and replaces bare bit synchronizers wherever a multi-bit word must cross domains coherently.

## Interface
Parameters:
- WIDTH, 32, data word width (≥1)
- STAGES, 2, synchronizer flops on src_req (≥2)

Ports:
- dest_clk  input  1  destination clock
- rst_n  input  1  reset, synchronous, active-low
- src_req  input  1  asynchronous request from source domain (level, four-phase)
- src_data  input  WIDTH  source data; stable from src_req rise until dest_ack is seen high by source
- dest_ack  output  1  acknowledge to source; driven directly from a flop, glitch-free
- m_valid  output  1  captured word available
- m_ready  input  1  downstream accepts word
- m_data  output  WIDTH  captured word
- busy  output  1  high whenever state ≠ IDLE

## Operation
- src_req passes through a STAGES-deep flop chain marked ASYNC_REG; req_s is the last flop. Chain resets to 0.
- src_data is not synchronized; it is sampled only when req_s is high, which guarantees stability.
- FSM states:
  - IDLE: dest_ack=0, m_valid=0. On req_s=1: m_data<=src_data, m_valid<=1, go to VALID.
  - VALID: m_valid=1, m_data held constant. On m_ready=1: m_valid<=0, dest_ack<=1, go to ACK. While m_ready=0, stay in VALID indefinitely.
  - ACK: dest_ack=1. On req_s=0: dest_ack<=0, go to IDLE. m_ready is ignored here.
- One word per handshake. A new capture requires req_s to return low through ACK, so a held-high src_req never produces a duplicate word.
- m_valid never drops without m_ready. m_data changes only on IDLE→VALID.
- An illegal FSM encoding returns to IDLE with dest_ack=0 and m_valid=0.

## Timing
- Reset values: dest_ack=0, m_valid=0, m_data=0, busy=0, state=IDLE, sync chain all 0. Reset overrides all other activity.
- Latency: if src_req is first sampled high at edge E0, req_s=1 after edge E0+STAGES−1. m_valid and m_data update at edge E0+STAGES.
- Accept: m_valid&&m_ready sampled at edge E gives m_valid=0 and dest_ack=1 after E. m_ready may be tied high, giving a 1-cycle VALID.
- Release: src_req sampled low at edge F gives dest_ack=0 and busy=0 after edge F+STAGES. IDLE can capture again at the next qualifying edge.
- Minimum destination cycles per word, with m_ready=1: 2·STAGES+2, plus source-side ack synchronization.
- Reset mid-transfer:
  - Any in-flight word is dropped and dest_ack drops.
  - If src_req is still high after reset, the word is captured again as a new transfer after STAGES+1 edges. Source protocol tolerates this.
- A src_req pulse shorter than one dest_clk period may be missed. This is a source protocol violation and is not detected.
- m_ready asserted while m_valid=0 has no effect.

## Test plan
- Basic transfer, WIDTH=32, STAGES=2, m_ready=1:
  - Stimulus: src_data=0xDEADBEEF; raise src_req before edge 0; drop src_req once dest_ack=1.
  - Required: m_valid=1 with m_data=0xDEADBEEF after edge 2; dest_ack=1 after edge 3; dest_ack=0 two edges after src_req is sampled low; exactly one word delivered.
- Backpressure:
  - Stimulus: m_ready=0 for 10 cycles after m_valid, then 1.
  - Required: m_valid and m_data (0x12345678) stable throughout; dest_ack stays 0 until the edge after m_ready=1.
- Held request:
  - Stimulus: keep src_req high for 20 cycles after dest_ack rises.
  - Required: no second m_valid; dest_ack stays 1 until src_req falls.
- Back-to-back words:
  - Stimulus: source sends 0x1, 0x2, 0x3 with a correct four-phase handshake and random m_ready.
  - Required: m_data sequence is exactly 1, 2, 3 with no loss or duplication.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 for 1 cycle while in VALID, with src_req held high.
  - Required: all outputs are 0 the cycle after reset; the word is re-delivered STAGES+1 edges after release.
- Parameter sweep STAGES=3, WIDTH=1:
  - Required: capture latency is 3 edges after src_req is first sampled high; the scenarios above pass.
